// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, sequencer state and key-event type
// used by the key sequencer and its event FIFO.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BRK      = 8'hF0;
  localparam logic [7:0] PS2_PAUSE    = 8'hE1;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_ERR0     = 8'h00;
  localparam logic [7:0] PS2_ERR1     = 8'hFF;
  localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;

  localparam logic [7:0] LSHIFT     = 8'h12;
  localparam logic [7:0] RSHIFT     = 8'h59;
  localparam logic [7:0] CTRL       = 8'h14;
  localparam logic [7:0] PAUSE_CODE = 8'h77;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_PAUSE
  } seq_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_evt_t;

  // Keyboard housekeeping replies: silently ignored, sequence untouched.
  function automatic logic is_status_drop(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) || (b == PS2_RESEND);
  endfunction

  function automatic logic is_status_err(input logic [7:0] b);
    return (b == PS2_ERR0) || (b == PS2_ERR1) || (b == PS2_BAT_FAIL);
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Circular key-event FIFO with extra-MSB pointers; a push into a full FIFO
// is dropped unless a pop frees a slot on the same edge.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  key_evt_t push_data_i,
  input  logic     pop_i,
  output key_evt_t head_o,
  output logic     valid_o,
  output logic     drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  key_evt_t    mem_q [DEPTH];
  logic        empty, full, do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && full && !do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the head is masked to zero while
  // empty, so stale entries are never visible and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign valid_o = !empty;
  assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ps2_key_sequencer.sv
// Turns the PS/2 byte stream into make/break key events (E0/F0 prefixes,
// Pause swallowing, status filtering, timeout) and tracks SHIFT/CTRL.
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd2000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       clk_en,
  input  logic [7:0] PS2_BYTE,
  input  logic       PS2_DONE,
  output logic [7:0] EVT_CODE,
  output logic       EVT_EXT,
  output logic       EVT_BREAK,
  output logic       EVT_VALID,
  input  logic       EVT_READY,
  output logic       SHIFT_HELD,
  output logic       CTRL_HELD,
  output logic       OVERFLOW,
  output logic       KB_ERROR,
  input  logic       ERR_CLEAR
);

  seq_state_e  state_q, state_d;
  logic        ext_q, ext_d;
  logic [2:0]  skip_q, skip_d;
  logic [15:0] tmo_q, tmo_d;
  logic        prev_done_q;
  logic        lshift_q, lshift_d, rshift_q, rshift_d;
  logic        lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic        overflow_q, kb_err_q;

  logic        byte_stb, emit, err_set, fifo_drop;
  key_evt_t    evt, head;

  // Rising edge of the receiver's level DONE, sampled only on ticks.
  assign byte_stb = clk_en && PS2_DONE && !prev_done_q;

  always_comb begin
    state_d = state_q;
    ext_d   = ext_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    emit    = 1'b0;
    err_set = 1'b0;
    evt     = '{code: PS2_BYTE, ext: 1'b0, brk: 1'b0};

    if (byte_stb) begin
      tmo_d = '0;
      if (is_status_err(PS2_BYTE)) begin
        err_set = 1'b1;
        state_d = ST_IDLE;
        ext_d   = 1'b0;
      end else if (!is_status_drop(PS2_BYTE)) begin
        unique case (state_q)
          ST_IDLE: begin
            if (PS2_BYTE == PS2_EXT) begin
              state_d = ST_EXT;
            end else if (PS2_BYTE == PS2_BRK) begin
              state_d = ST_BRK;
              ext_d   = 1'b0;
            end else if (PS2_BYTE == PS2_PAUSE) begin
              state_d = ST_PAUSE;
              skip_d  = 3'd7;
            end else begin
              emit = 1'b1;
            end
          end
          ST_EXT: begin
            if (PS2_BYTE == PS2_BRK) begin
              state_d = ST_BRK;
              ext_d   = 1'b1;
            end else begin
              state_d = ST_IDLE;
              // E0 12 is the keyboard's synthetic shift around extended keys.
              emit    = (PS2_BYTE != LSHIFT);
              evt.ext = 1'b1;
            end
          end
          ST_BRK: begin
            state_d = ST_IDLE;
            ext_d   = 1'b0;
            emit    = !(ext_q && PS2_BYTE == LSHIFT);
            evt.ext = ext_q;
            evt.brk = 1'b1;
          end
          ST_PAUSE: begin
            skip_d = skip_q - 3'd1;
            if (skip_q == 3'd1) begin
              state_d  = ST_IDLE;
              emit     = 1'b1;
              evt.code = PAUSE_CODE;
              evt.ext  = 1'b1;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (clk_en && state_q != ST_IDLE) begin
      tmo_d = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
      if (tmo_d >= TIMEOUT_TICKS) begin
        err_set = 1'b1;
        state_d = ST_IDLE;
        ext_d   = 1'b0;
      end
    end
  end

  // Modifiers follow every emitted event, even one the FIFO drops.
  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    if (emit) begin
      if (!evt.ext && evt.code == LSHIFT) lshift_d = !evt.brk;
      if (!evt.ext && evt.code == RSHIFT) rshift_d = !evt.brk;
      if (evt.code == CTRL) begin
        if (evt.ext) rctrl_d = !evt.brk;
        else         lctrl_d = !evt.brk;
      end
    end
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      ext_q       <= 1'b0;
      skip_q      <= '0;
      tmo_q       <= '0;
      prev_done_q <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      overflow_q  <= 1'b0;
      kb_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ext_q      <= ext_d;
      skip_q     <= skip_d;
      tmo_q      <= tmo_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      lctrl_q    <= lctrl_d;
      rctrl_q    <= rctrl_d;
      if (clk_en) prev_done_q <= PS2_DONE;
      // A new error on the clearing edge keeps its flag set.
      overflow_q <= fifo_drop | (overflow_q & ~ERR_CLEAR);
      kb_err_q   <= err_set   | (kb_err_q   & ~ERR_CLEAR);
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (RESET),
    .push_i      (emit),
    .push_data_i (evt),
    .pop_i       (EVT_READY),
    .head_o      (head),
    .valid_o     (EVT_VALID),
    .drop_o      (fifo_drop)
  );

  assign EVT_CODE   = head.code;
  assign EVT_EXT    = head.ext;
  assign EVT_BREAK  = head.brk;
  assign SHIFT_HELD = lshift_q | rshift_q;
  assign CTRL_HELD  = lctrl_q | rctrl_q;
  assign OVERFLOW   = overflow_q;
  assign KB_ERROR   = kb_err_q;

endmodule

// File: doc/ps2_key_sequencer.md
# ps2_key_sequencer

Sequences the byte stream produced by the PS/2 receiver into complete key events. It sits between the PS/2 byte receiver and the BBC keyboard-matrix emulation. It strips the E0 (extended) and F0 (break) prefix bytes, swallows the 8-byte Pause sequence and filters keyboard status bytes. Finished events are buffered in a small FIFO behind a valid/ready handshake, and live SHIFT/CTRL state is tracked for the matrix.

## Interface
- FIFO_DEPTH, 4 — event FIFO entries; power of two, 2..16
- TIMEOUT_TICKS, 16'd2000 — clk_en ticks allowed between bytes of one multi-byte sequence
- clk  in  1  system clock; all state on posedge
- RESET  in  1  asynchronous, active-high reset
- clk_en  in  1  tick enable; all sequencing and timeout advance only when high
- PS2_BYTE  in  8  received scan byte; valid while PS2_DONE high
- PS2_DONE  in  1  level flag from the receiver; held high across one or more clk_en ticks per byte
- EVT_CODE  out  8  scan code of FIFO head
- EVT_EXT  out  1  head event was E0-prefixed
- EVT_BREAK  out  1  head event is a release
- EVT_VALID  out  1  FIFO non-empty
- EVT_READY  in  1  consumer accepts head when EVT_VALID & EVT_READY at a clk edge; this does not depend on clk_en
- SHIFT_HELD  out  1  left (12) or right (59) shift currently down
- CTRL_HELD  out  1  left (14) or E0-14 ctrl currently down
- OVERFLOW  out  1  sticky: an event was dropped because the FIFO was full
- KB_ERROR  out  1  sticky: 00/FF overrun, FC BAT fail, or sequence timeout
- ERR_CLEAR  in  1  synchronous clear of OVERFLOW and KB_ERROR

## Operation
- Byte strobe: on a clk_en tick, a byte is taken when PS2_DONE=1 and the previous sampled PS2_DONE=0. The receiver's multi-tick DONE must yield exactly one byte.
- FSM states:
  - IDLE
  - EXT: E0 seen
  - BRK: F0 seen; ext flag retained
  - PAUSE: skip counter 3 bits
- IDLE transitions:
  - E0 → EXT
  - F0 → BRK (ext=0)
  - E1 → PAUSE, skip=7
  - other data code → emit {code, ext=0, brk=0}
- EXT transitions:
  - F0 → BRK (ext=1)
  - 12 → discard (fake shift) and return to IDLE
  - else → emit {code, 1, 0} and return to IDLE
- BRK transitions:
  - any byte → emit {code, ext, 1} and return to IDLE
  - E0-F0-12 is discarded
- PAUSE: each byte decrements skip; at 0, emit {77, ext=1, brk=0} and return to IDLE. No break event is emitted for Pause.
- Status bytes, in any state:
  - AA, FA, EE, FE are dropped and do not change state.
  - 00, FF, FC set KB_ERROR and force IDLE.
- Timeout: a 16-bit counter is cleared on every byte and increments per clk_en while the state is not IDLE. When it reaches TIMEOUT_TICKS, set KB_ERROR and force IDLE. It saturates and never wraps.
- Modifiers update on emit, regardless of whether the FIFO accepts the event:
  - 12 or 59 non-ext make/break sets/clears SHIFT bits.
  - 14 make/break with either ext value sets/clears CTRL bits (left/right held separately, ORed).
- FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1 bit pointers. Full means the MSBs differ and the rest match.
  - Push when full: drop the new event and set OVERFLOW.
  - Simultaneous push and pop when full: the pop frees a slot and the push succeeds.
  - Pop when empty: ignored.
- ERR_CLEAR in the same cycle as a new error: the error wins and the flag stays 1.

## Timing
- Reset values: FSM IDLE, FIFO empty, EVT_VALID=0, EVT_CODE=00, EVT_EXT=0, EVT_BREAK=0, SHIFT_HELD=0, CTRL_HELD=0, OVERFLOW=0, KB_ERROR=0, timeout=0, prev-DONE=0.
- Latency: an event is written on the clk edge of the clk_en tick that takes the final byte. EVT_VALID is high the following cycle (1 clk).
- EVT_* outputs are registered head data. They are stable while EVT_VALID=1 and EVT_READY=0.
- RESET asserted mid-sequence or mid-Pause discards the partial sequence and all FIFO contents.

## Structure
- Shared package `ps2_pkg`: scan constants PS2_EXT=E0, PS2_BRK=F0, PS2_PAUSE=E1, PS2_BAT_OK=AA, PS2_ACK=FA, PS2_ECHO=EE, PS2_RESEND=FE, PS2_ERR0=00, PS2_ERR1=FF, PS2_BAT_FAIL=FC; key codes LSHIFT=12, RSHIFT=59, CTRL=14; FSM state enum; event struct {code[7:0], ext, brk}.
- Sub-module `ps2_event_fifo`: parameterised FIFO_DEPTH × 10-bit synchronous FIFO with full/empty and a drop-on-full output. The sequencer FSM, timeout and modifier tracking stay in the top module.

## Test plan
- Bytes 1C; F0 1C → events {1C,0,0} then {1C,0,1}. DONE held for 3 clk_en ticks per byte yields exactly 2 events.
- E0 75; E0 F0 75 → {75,1,0}, {75,1,1}. E0 12 E0 7C → only {7C,1,0}.
- E1 14 77 E1 F0 14 F0 77 → exactly one event {77,1,0}; FSM back in IDLE; next byte 1C → {1C,0,0}.
- 12 → SHIFT_HELD=1; F0 12 → SHIFT_HELD=0. 14 then E0 14 then F0 14 → CTRL_HELD stays 1 until E0 F0 14.
- EVT_READY=0, send 5 makes with FIFO_DEPTH=4 → 4 events retained in order, 5th dropped, OVERFLOW=1. ERR_CLEAR → 0.
- E0 then no bytes for TIMEOUT_TICKS ticks → KB_ERROR=1 and IDLE; next 1C → {1C,0,0} (not extended). Byte FF mid-F0 → KB_ERROR=1, no event.
